// File: rtl/load_store_unit.sv
// Load/store unit: turns byte, halfword and word requests into word-only
// memory accesses. Sub-word stores use a read-modify-write sequence.
// It also checks for size, alignment and range faults when a request is accepted.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_FAULT = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t      state_q;
    logic        write_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic        resp_valid_q;
    logic        resp_fault_q;
    logic [31:0] resp_rdata_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;

    logic        size_fault_s;
    logic        range_fault_s;
    logic        fault_s;

    // Pick the addressed lane of a memory word and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of a memory word with the low store bits.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r = word;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    // Reserved size or misalignment of the incoming request.
    always_comb begin
        size_fault_s = 1'b0;
        case (req_size)
            2'b00:   size_fault_s = 1'b0;
            2'b01:   size_fault_s = req_addr[0];
            2'b10:   size_fault_s = (req_addr[1:0] != 2'b00);
            default: size_fault_s = 1'b1;
        endcase
    end

    assign range_fault_s = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    assign fault_s       = size_fault_s | range_fault_s;

    // Request FSM: capture at acceptance, read/merge/write, one-cycle response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_fault_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        write_q    <= req_write;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        lane_q     <= req_addr[1:0];
                        if (fault_s) begin
                            state_q <= S_FAULT;
                        end else if (req_write && (req_size == 2'b10)) begin
                            state_q     <= S_WRITE;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            mem_wdata_q <= req_wdata;
                        end else begin
                            state_q     <= S_READ;
                            mem_addr_q  <= {req_addr[31:2], 2'b00};
                            // Sub-word stores keep their data here until the merge.
                            mem_wdata_q <= req_write ? req_wdata : mem_wdata_q;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_READ: begin
                    if (write_q) begin
                        mem_wdata_q <= store_merge(mem_rdata, mem_wdata_q, size_q, lane_q);
                        state_q     <= S_WRITE;
                    end else begin
                        resp_rdata_q <= load_extract(mem_rdata, size_q, lane_q, unsigned_q);
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_FAULT: begin
                    resp_valid_q <= 1'b1;
                    resp_fault_q <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    resp_fault_q <= 1'b0;
                    resp_rdata_q <= 32'd0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    // The write strobe is decoded from state so an async reset kills it immediately.
    assign mem_write  = (state_q == S_WRITE);
    assign req_ready  = rst_n & (state_q == S_IDLE);
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_fault = resp_fault_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 32-word behavioural memory.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:31] = '{default: 32'd0};
    int wr_count   = 0;
    int resp_count = 0;
    int wr_before  = 0;
    int resp_before = 0;
    int checks = 0;
    int errors = 0;
    int gap;
    bit no_resp;

    load_store_unit #(.MEM_WORDS(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    // Combinational read of aligned in-range words.
    assign mem_rdata = (mem_addr[31:7] == 25'd0 && mem_addr[1:0] == 2'b00) ? mem[mem_addr[6:2]] : 32'd0;

    // Synchronous write plus counters of write strobes and response pulses.
    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr[6:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (resp_valid) begin
            resp_count <= resp_count + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        chk("ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        wr_before   = wr_count;
        resp_before = resp_count;
    endtask

    // Latency counts the acceptance edge as 1.
    task automatic wait_resp(input string tag, input int exp_lat, input logic [31:0] exp_rdata,
                             input logic exp_fault, input int exp_writes);
        int lat;
        bit seen;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_seen"},  {31'd0, seen}, 32'd1);
        chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
        chk({tag, "_rdata"}, resp_rdata, exp_rdata);
        chk({tag, "_fault"}, {31'd0, resp_fault}, {31'd0, exp_fault});
        @(posedge clk);
        #1;
        chk({tag, "_after"}, {29'd0, resp_valid, resp_fault, req_ready}, 32'd1);
        chk({tag, "_after_rdata"}, resp_rdata, 32'd0);
        chk({tag, "_writes"}, 32'(wr_count - wr_before), 32'(exp_writes));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp", {30'd0, resp_valid, resp_fault}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of a word store's WRITE cycle
        issue(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF);
        chk("midw_mem_write", {31'd0, mem_write}, 32'd1);
        chk("midw_mem_addr", mem_addr, 32'h08);
        chk("midw_mem_wdata", mem_wdata, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        chk("midw_write_drop", {31'd0, mem_write}, 32'd0);
        chk("midw_ready_in_rst", {31'd0, req_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midw_ready_after", {31'd0, req_ready}, 32'd1);
        no_resp = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (resp_valid) no_resp = 1'b0;
        end
        chk("midw_no_resp", {31'd0, no_resp}, 32'd1);
        chk("midw_resp_count", 32'(resp_count - resp_before), 32'd0);
        chk("midw_writes", 32'(wr_count - wr_before), 32'd0);
        chk("midw_word2", mem[2], 32'd0);

        // Word store then word load
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
        wait_resp("sw10", 2, 32'd0, 1'b0, 1);
        chk("sw10_mem", mem[4], 32'h12345678);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
        wait_resp("lw10", 2, 32'h12345678, 1'b0, 0);

        // Byte read-modify-write and byte loads
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hAABBCCDD);
        wait_resp("sw_pre", 2, 32'd0, 1'b0, 1);
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5E);
        wait_resp("sb11", 3, 32'd0, 1'b0, 1);
        chk("sb11_mem", mem[4], 32'hAABB5EDD);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'd0);
        wait_resp("lb13", 2, 32'hFFFFFFAA, 1'b0, 0);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'd0);
        wait_resp("lbu13", 2, 32'h000000AA, 1'b0, 0);
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'd0);
        wait_resp("lb11", 2, 32'h0000005E, 1'b0, 0);

        // Halfword store and loads
        issue(1'b1, 2'b01, 1'b0, 32'h06, 32'h12348001);
        wait_resp("sh06", 3, 32'd0, 1'b0, 1);
        chk("sh06_mem", mem[1], 32'h80010000);
        issue(1'b0, 2'b01, 1'b0, 32'h06, 32'd0);
        wait_resp("lh06", 2, 32'hFFFF8001, 1'b0, 0);
        issue(1'b0, 2'b01, 1'b1, 32'h06, 32'd0);
        wait_resp("lhu06", 2, 32'h00008001, 1'b0, 0);
        issue(1'b0, 2'b01, 1'b1, 32'h04, 32'd0);
        wait_resp("lhu04", 2, 32'h00000000, 1'b0, 0);

        // Highest valid word
        issue(1'b1, 2'b10, 1'b0, 32'h7C, 32'hCAFEF00D);
        wait_resp("sw7c", 2, 32'd0, 1'b0, 1);
        issue(1'b0, 2'b10, 1'b0, 32'h7C, 32'd0);
        wait_resp("lw7c", 2, 32'hCAFEF00D, 1'b0, 0);

        // Faults: misaligned, out of range, reserved size
        issue(1'b0, 2'b10, 1'b0, 32'h02, 32'd0);
        wait_resp("f_lw02", 2, 32'd0, 1'b1, 0);
        issue(1'b1, 2'b01, 1'b0, 32'h03, 32'hFFFFFFFF);
        wait_resp("f_sh03", 2, 32'd0, 1'b1, 0);
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'd0);
        wait_resp("f_lw80", 2, 32'd0, 1'b1, 0);
        issue(1'b1, 2'b10, 1'b0, 32'h80, 32'h55555555);
        wait_resp("f_sw80", 2, 32'd0, 1'b1, 0);
        issue(1'b1, 2'b11, 1'b0, 32'h00, 32'h66666666);
        wait_resp("f_size3", 2, 32'd0, 1'b1, 0);
        chk("f_mem0", mem[0], 32'd0);
        chk("f_mem1", mem[1], 32'h80010000);
        chk("f_mem4", mem[4], 32'hAABB5EDD);

        // req_valid held high with changing fields during a byte store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hFFFFFF77;
        @(posedge clk);
        #1;
        wr_before = wr_count;
        resp_before = resp_count;
        gap = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready) begin
                req_write = 1'b0; req_size = 2'b10; req_addr = 32'h20;
                @(posedge clk);
                gap++;
                break;
            end
            req_write = 1'b1; req_size = 2'b10;
            req_addr = 32'h24 + 32'(4 * k); req_wdata = 32'hBAD00000 + 32'(k);
            @(posedge clk);
            gap++;
        end
        #1;
        req_valid = 1'b0;
        chk("hold_accept_gap", 32'(gap), 32'd4);
        chk("hold_first_resp", 32'(resp_count - resp_before), 32'd1);
        chk("hold_writes", 32'(wr_count - wr_before), 32'd1);
        chk("hold_mem8", mem[8], 32'h00000077);
        chk("hold_mem9", mem[9], 32'd0);
        chk("hold_mem10", mem[10], 32'd0);
        wr_before = wr_count;
        resp_before = resp_count;
        wait_resp("hold_lw20", 2, 32'h00000077, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
